spi_frame_ctrl: RTL
===================

# spi_frame_ctrl

Byte-level transaction controller for the PSEC5 SPI peripheral, clocked entirely by `sclk`. It deserializes the PICO bit stream into an address/command byte followed by data bytes. It sequences auto-incrementing register writes (addresses 1–3: trigger_channel_mask, instruction, mode) and register reads (addresses 1–MAX_ADDR) onto `serial_out`. Frames are delimited by reset: the parent drives `rstn` from the combined external and sclk-stop reset, so every frame starts in a clean state.

## Interface
- MAX_ADDR, 59, highest valid register address; the pointer wraps from MAX_ADDR to 1
- WR_LO, 1, lowest writable address
- WR_HI, 3, highest writable address
- sclk  in  1  SPI clock; all state updates on posedge
- rstn  in  1  asynchronous, active-low reset (external reset AND sclk-stop reset)
- serial_in  in  1  controller-to-peripheral data, MSB first, sampled on posedge sclk
- serial_out  out  1  peripheral-to-controller data, registered, MSB first
- rd_data  in  8  combinational register-bank data for `rd_addr`
- rd_addr  out  7  registered read pointer
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  7  write address, valid while wr_en=1
- wr_data  out  8  write data, valid while wr_en=1
- frame_active  out  1  high once the address byte has been accepted (state ≠ ADDR)
- addr_err  out  1  sticky error flag for the frame

## Operation
- Datapath registers: 3-bit `bit_cnt`, 8-bit `rx_shift`, 8-bit `tx_shift`, 7-bit `ptr`, 2-bit state.
- Every posedge: `rx_shift <= {rx_shift[6:0], serial_in}` and `bit_cnt <= bit_cnt+1` (wraps 7→0). A byte completes on the posedge where `bit_cnt==7`; the completed byte is `{rx_shift[6:0], serial_in}`.
- Address byte format: bit 7 = W (1 = write, 0 = read); bits 6:0 = start address A.
- State ADDR (reset state). On byte completion:
  - A==0 or A>MAX_ADDR → IGNORE, addr_err=1.
  - Otherwise `ptr<=A` and go to WRITE (W=1) or READ (W=0).
- State WRITE. On each byte completion:
  - If WR_LO≤ptr≤WR_HI: next cycle wr_en=1, wr_addr=ptr, wr_data=byte.
  - Otherwise: no strobe, addr_err=1.
  - In both cases, ptr advances.
- State READ:
  - On the posedge with `bit_cnt==0` (first bit of each data byte): `serial_out<=rd_data[7]`, `tx_shift<={rd_data[6:0],1'b0}`.
  - On every other posedge: `serial_out<=tx_shift[7]` and tx_shift shifts left.
  - ptr advances on each byte completion.
  - Bits of the host byte received during READ are ignored.
- State IGNORE: all input is discarded; serial_out=0; no strobes. The state is left only by reset.
- Pointer advance: `ptr <= (ptr==MAX_ADDR) ? 1 : ptr+1`. The pointer never takes the value 0.
- rd_addr = ptr in all states.
- No transition returns the block to ADDR except rstn.

## Timing
- Reset values: state=ADDR, bit_cnt=0, rx_shift=0, tx_shift=0, ptr=1, serial_out=0, wr_en=0, wr_addr=0, wr_data=0, frame_active=0, addr_err=0. Reset is asynchronous on assertion.
- Address byte: 8 posedges (cycles 0–7); state and ptr update at the cycle-7 edge.
- Write latency: wr_en rises after the 8th posedge of the data byte and falls after the next posedge. wr_addr and wr_data hold their values until the next strobe.
- Consecutive write bytes give one strobe every 8 cycles with no gaps.
- Read latency:
  - rd_data must settle within one sclk period after ptr changes.
  - Bit 7 of data byte N appears after the first posedge of byte N; bit 0 appears after the 8th posedge.
  - The host samples each bit at the following posedge, so the stream is one-bit-lagged.
- Wrap-around: a write or read spanning MAX_ADDR continues at 1 (and at 2, 3, …) with no gap.
- Simultaneous events: a byte completion in WRITE updates the strobe outputs and ptr on the same edge; a write to an illegal address sets addr_err on the same edge the strobe would have been issued.
- Reset mid-byte: the partial byte is discarded. Reset during an active wr_en clears it immediately. The target latches gate on wr_en, so no write occurs after reset.
- A partial final byte (sclk stops before bit 8) produces no strobe.

## Test plan
- Write frame `0x82, 0xA5` → one wr_en pulse after posedge 16 with wr_addr=2, wr_data=0xA5; addr_err=0; frame_active=1 from posedge 8.
- Burst write `0x81, 0x11, 0x22, 0x33, 0x44` → strobes at addresses 1, 2, 3 with data 0x11, 0x22, 0x33; the fourth byte (ptr=4) produces no strobe and sets addr_err=1.
- Read frame `0x3A`, then 16 dummy clocks, with the bank returning 0xC3 for address 58 and 0x5A for address 59:
  - rd_addr steps 58 → 59 → 1.
  - serial_out produces 1100_0011 then 0101_1010.
- Address byte `0x00` (and separately `0x7F`) → state IGNORE, addr_err=1, serial_out held at 0, no wr_en for any subsequent bytes.
- Write `0x83`, then 5 bits of `0xFF`, then assert rstn low → no wr_en, all outputs at reset values. A new frame `0x81, 0x0F` then writes 0x0F to address 1.
- Read with MAX_ADDR=3, starting at address 3 for 3 bytes → rd_addr sequence 3, 1, 2; serial_out matches the bank at each address.

Source files
------------

// File: rtl/spi_frame_ctrl.sv
// SPI byte-level frame controller: address byte, then auto-incrementing
// register writes or MSB-first read-back, all on sclk.
//
// state     | meaning
// ST_ADDR   | collecting the address/command byte
// ST_WRITE  | each data byte strobes a write to ptr, ptr advances
// ST_READ   | shifting rd_data out on serial_out, ptr advances per byte
// ST_IGNORE | bad start address; discard everything until reset
module spi_frame_ctrl #(
  parameter int MAX_ADDR = 59,
  parameter int WR_LO    = 1,
  parameter int WR_HI    = 3
) (
  input  logic       sclk,
  input  logic       rstn,
  input  logic       serial_in,
  output logic       serial_out,
  input  logic [7:0] rd_data,
  output logic [6:0] rd_addr,
  output logic       wr_en,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_active,
  output logic       addr_err
);

  typedef enum logic [1:0] {
    ST_ADDR   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_READ   = 2'd2,
    ST_IGNORE = 2'd3
  } state_t;

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);
  localparam logic [6:0] LO_A  = 7'(WR_LO);
  localparam logic [6:0] HI_A  = 7'(WR_HI);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  // The eighth bit of a byte is serial_in itself, so only seven bits of history are kept.
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [6:0] ptr_q, ptr_d;
  logic       serial_out_q, serial_out_d;
  logic       wr_en_q, wr_en_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       frame_active_q, frame_active_d;
  logic       addr_err_q, addr_err_d;

  logic       byte_done;
  logic [7:0] rx_byte;
  logic [6:0] ptr_next;

  assign byte_done = (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_shift_q, serial_in};
  assign ptr_next  = (ptr_q == MAX_A) ? 7'd1 : ptr_q + 7'd1;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q + 3'd1;
    rx_shift_d   = rx_byte[6:0];
    tx_shift_d   = tx_shift_q;
    ptr_d        = ptr_q;
    serial_out_d = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    addr_err_d   = addr_err_q;

    case (state_q)
      ST_ADDR: begin
        if (byte_done) begin
          if ((rx_byte[6:0] == 7'd0) || (rx_byte[6:0] > MAX_A)) begin
            state_d    = ST_IGNORE;
            addr_err_d = 1'b1;
          end else begin
            ptr_d   = rx_byte[6:0];
            state_d = rx_byte[7] ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (byte_done) begin
          if ((ptr_q >= LO_A) && (ptr_q <= HI_A)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = rx_byte;
          end else begin
            addr_err_d = 1'b1;
          end
          ptr_d = ptr_next;
        end
      end
      ST_READ: begin
        // rd_data is sampled fresh at the first bit of every byte, after ptr has settled.
        if (bit_cnt_q == 3'd0) begin
          serial_out_d = rd_data[7];
          tx_shift_d   = {rd_data[6:0], 1'b0};
        end else begin
          serial_out_d = tx_shift_q[7];
          tx_shift_d   = {tx_shift_q[6:0], 1'b0};
        end
        if (byte_done) ptr_d = ptr_next;
      end
      default: ;
    endcase

    frame_active_d = (state_d != ST_ADDR);
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_ADDR;
      bit_cnt_q      <= 3'd0;
      rx_shift_q     <= 7'd0;
      tx_shift_q     <= 8'd0;
      ptr_q          <= 7'd1;
      serial_out_q   <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= 7'd0;
      wr_data_q      <= 8'd0;
      frame_active_q <= 1'b0;
      addr_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      tx_shift_q     <= tx_shift_d;
      ptr_q          <= ptr_d;
      serial_out_q   <= serial_out_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      frame_active_q <= frame_active_d;
      addr_err_q     <= addr_err_d;
    end
  end

  assign serial_out   = serial_out_q;
  assign rd_addr      = ptr_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign frame_active = frame_active_q;
  assign addr_err     = addr_err_q;

endmodule
